mult_share_arbiter: RTL and testbench
=====================================

# mult_share_arbiter

Sequenced front end that shares one signed 32×32 multiplier among NREQ requesters. Arbitrates incoming multiply requests, latches the winner's operands, runs the multiply in the `signed_mult_32` sub-module and holds the 64-bit signed product until the consumer accepts it. Sits between the requesting datapath units and the single multiplier instance, so only one multiplier is built per cluster.

## Interface
- NREQ, 4, number of requesters (2..16)
- IDW, $clog2(NREQ), width of requester ID
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_a  in  NREQ*32  packed multiplicand, requester i at [32i+31:32i], signed
- req_b  in  NREQ*32  packed multiplier, same packing, signed
- rsp_valid  out  1  product valid
- rsp_ready  in  1  consumer accepts product
- rsp_id  out  IDW  index of requester that owns the product
- rsp_result  out  64  signed product a*b
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, CALC, RESP.
- IDLE: grant is computed combinationally from req_valid and the priority pointer; req_ready[g]=1 for the granted index g only. If any req_valid is high: latch req_a/req_b slice g and ID g, go to CALC. Otherwise stay.
- CALC: the multiplier evaluates the latched operands; the product is registered into rsp_result; go to RESP.
- RESP: rsp_valid=1, rsp_id/rsp_result stable. On rsp_ready=1, return to IDLE. Otherwise hold all outputs.
- req_ready is 0 in CALC and RESP. Requesters hold valid and operands until their ready pulse; deasserting valid before grant is legal and removes the request.
- Arithmetic: full two's-complement 32×32→64, exact for all inputs, including -2^31 operands (0x80000000 × 0x80000000 = 0x4000000000000000). Negation of magnitude and product is 64-bit wide; no truncation or saturation.
- Priority pointer is updated only on a grant: ptr ← (g+1) mod NREQ, wrapping from NREQ-1 to 0.
- Reset: state=IDLE, ptr=0. All outputs read 0: req_ready=0 (no valid after reset), rsp_valid=0, rsp_id=0, rsp_result=0, busy=0. Reset asserted in CALC/RESP discards the in-flight operation; no response is produced.
- Requests arriving while busy are not lost. They stay pending on req_valid and are arbitrated on return to IDLE.

## Timing
- Request handshake at edge T (req_valid & req_ready). State is CALC in T+1. rsp_valid=1 from T+2.
- Response handshake at edge R (rsp_valid & rsp_ready). State is IDLE in R+1. The next grant handshake occurs at the earliest at edge R+1.
- Minimum issue interval is 3 cycles, with rsp_ready tied high.
- No combinational path from rsp_ready to req_ready. There is a combinational path from req_valid to req_ready in IDLE only.

## Configuration
- MULT_ARB_RR_EN defined: round-robin arbitration. The search starts at ptr and takes the first valid index upward with wrap.
- MULT_ARB_RR_EN undefined: fixed priority. The lowest valid index wins, and the pointer logic is not built.

## Structure
- Package `mult_arb_pkg` holds the state enum (IDLE, CALC, RESP), the operand width constant 32, the product width constant 64, and the default NREQ.
- Sub-module `signed_mult_32` is a combinational signed 32×32→64 multiplier, instantiated once and fed from the latched operand registers.
- The arbiter function (pointer plus valid vector to one-hot grant) lives inside mult_share_arbiter.

## Test plan
- Single request, req 2: a=7, b=-3. Expected: req_ready[2] on the same cycle; rsp_valid two cycles later with rsp_id=2 and rsp_result=0xFFFFFFFFFFFFFFEB.
- Corner operands on req 0 (rsp_ready=1):
  - a=b=0x80000000 gives 0x4000000000000000.
  - a=0x80000000, b=1 gives 0xFFFFFFFF80000000.
  - a=0x7FFFFFFF, b=0x7FFFFFFF gives 0x3FFFFFFF00000001.
- All four req_valid held high, rsp_ready=1, RR_EN defined. Expected grant order 0,1,2,3,0, one grant every 3 cycles. Without the macro, req 0 wins every time.
- Backpressure: rsp_ready=0 for 5 cycles in RESP. Expected: rsp_valid, rsp_id and rsp_result stable; req_ready all 0; completion one cycle after rsp_ready rises.
- Reset pulsed in CALC. Expected next cycle: all outputs 0, state IDLE, ptr 0. A pending req_valid[1] is then granted first.
- Request withdrawn: req_valid[3] high one cycle while busy, then low. Expected: never granted, no response for ID 3.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// Shared types and widths for the multiplier-sharing arbiter.
// Holds the FSM state enum, operand/product widths and the default requester count.
package mult_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int OPW          = 32;
  localparam int PRODW        = 64;
  localparam int NREQ_DEFAULT = 4;

endpackage

// File: rtl/signed_mult_32.sv
// Combinational two's-complement 32x32 -> 64 multiplier.
// Both operands are sign-extended to the product width first, so -2^31 inputs are exact.
module signed_mult_32
  import mult_arb_pkg::*;
(
  input  logic [OPW-1:0]   i_a,
  input  logic [OPW-1:0]   i_b,
  output logic [PRODW-1:0] o_p
);

  logic signed [PRODW-1:0] w_a_ext;
  logic signed [PRODW-1:0] w_b_ext;

  assign w_a_ext = {{(PRODW-OPW){i_a[OPW-1]}}, i_a};
  assign w_b_ext = {{(PRODW-OPW){i_b[OPW-1]}}, i_b};
  // Low PRODW bits of the extended product equal the exact signed result.
  assign o_p     = w_a_ext * w_b_ext;

endmodule

// File: rtl/mult_share_arbiter.sv
// Arbitrates NREQ requesters onto one shared signed 32x32 multiplier (IDLE -> CALC -> RESP).
// Define MULT_ARB_RR_EN for round-robin arbitration; otherwise the lowest valid index wins.
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*OPW-1:0]   req_a,
  input  logic [NREQ*OPW-1:0]   req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [PRODW-1:0]      rsp_result,
  output logic                  busy
);

  state_t             r_state;
  state_t             w_state_next;
  logic [NREQ-1:0]    w_grant;
  logic [IDW-1:0]     w_grant_idx;
  logic               w_any;
  logic               w_hs;
  logic [OPW-1:0]     w_a_arr [NREQ];
  logic [OPW-1:0]     w_b_arr [NREQ];
  logic [OPW-1:0]     r_a;
  logic [OPW-1:0]     r_b;
  logic [IDW-1:0]     r_id;
  logic [PRODW-1:0]   r_result;
  logic [PRODW-1:0]   w_prod;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_a_arr[gi] = req_a[gi*OPW +: OPW];
      assign w_b_arr[gi] = req_b[gi*OPW +: OPW];
    end
  endgenerate

`ifdef MULT_ARB_RR_EN
  logic [IDW-1:0] r_ptr;

  // Scan upward from the pointer with wrap; first valid index wins.
  always_comb begin
    w_grant     = '0;
    w_grant_idx = '0;
    w_any       = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_any && req_valid[(int'(r_ptr) + k) % NREQ]) begin
        w_any                                  = 1'b1;
        w_grant[(int'(r_ptr) + k) % NREQ]      = 1'b1;
        w_grant_idx                            = IDW'((int'(r_ptr) + k) % NREQ);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_hs) begin
      r_ptr <= (w_grant_idx == IDW'(NREQ-1)) ? '0 : w_grant_idx + 1'b1;
    end
  end
`else
  always_comb begin
    w_grant     = '0;
    w_grant_idx = '0;
    w_any       = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_any && req_valid[k]) begin
        w_any       = 1'b1;
        w_grant[k]  = 1'b1;
        w_grant_idx = IDW'(k);
      end
    end
  end
`endif

  assign w_hs = w_any && (r_state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_state_next = CALC;
      CALC:    w_state_next = RESP;
      RESP:    if (rsp_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // req_ready depends on req_valid only through the grant; rsp_ready never reaches it.
  always_comb begin
    req_ready = (r_state == IDLE) ? w_grant : '0;
    rsp_valid = (r_state == RESP);
    busy      = (r_state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_id     <= '0;
      r_result <= '0;
    end else begin
      if (w_hs) begin
        r_a  <= w_a_arr[w_grant_idx];
        r_b  <= w_b_arr[w_grant_idx];
        r_id <= w_grant_idx;
      end
      if (r_state == CALC) begin
        r_result <= w_prod;
      end
    end
  end

  signed_mult_32 u_mult (
    .i_a (r_a),
    .i_b (r_b),
    .o_p (w_prod)
  );

  assign rsp_id     = r_id;
  assign rsp_result = r_result;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter; expectations come from a behavioural model.
// Honours MULT_ARB_RR_EN the same way as the design (round-robin vs fixed priority).
module tb_mult_share_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*32-1:0]  req_a = '0;
  logic [NREQ*32-1:0]  req_b = '0;
  logic                rsp_valid;
  logic                rsp_ready = 1'b0;
  logic [IDW-1:0]      rsp_id;
  logic [63:0]         rsp_result;
  logic                busy;

  int checks = 0;
  int errors = 0;
  int m_ptr = 0;
  int cyc_cnt = 0;
  bit watch3 = 1'b0;
  int seen3 = 0;

  mult_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
  always @(negedge clk) if (watch3 && req_ready[3]) seen3 <= seen3 + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference arbiter: first valid index at or after the start point, with wrap.
  function automatic int model_grant(logic [NREQ-1:0] v, int ptr);
    int start;
`ifdef MULT_ARB_RR_EN
    start = ptr;
`else
    start = 0;
`endif
    for (int k = 0; k < NREQ; k++) begin
      if (v[(start + k) % NREQ]) return (start + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [63:0] model_prod(logic [31:0] a, logic [31:0] b);
    longint sa, sb;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    return sa * sb;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int idx, input logic [31:0] a, input logic [31:0] b);
    req_a[idx*32 +: 32] = a;
    req_b[idx*32 +: 32] = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (2) cyc();
    rst = 1'b0;
    m_ptr = 0;
  endtask

  // One full request/response transaction starting from IDLE; hold = RESP cycles with rsp_ready low.
  task automatic transact(input logic [NREQ-1:0] v, input int hold, input bit keep,
                          output int gid, output logic [63:0] res, output int gcyc);
    int g;
    logic [31:0] a, b;
    logic [63:0] exp_p;
    logic [NREQ-1:0] exp_rdy;
    gid = -1; res = '0; gcyc = 0;
    req_valid = v;
    rsp_ready = (hold == 0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_before_req: busy=%b rsp_valid=%b required 0 0", busy, rsp_valid);
    end
    g = model_grant(v, m_ptr);
    exp_rdy = (g >= 0) ? NREQ'(1 << g) : '0;
    checks++;
    if (req_ready !== exp_rdy) begin
      errors++;
      $display("FAIL grant: valid=%b req_ready=%b required %b", v, req_ready, exp_rdy);
    end
    if (g < 0) begin
      cyc();
      return;
    end
    gid = g;
    a = req_a[g*32 +: 32];
    b = req_b[g*32 +: 32];
    exp_p = model_prod(a, b);
    cyc();
    gcyc = cyc_cnt;
    m_ptr = (g + 1) % NREQ;
    if (!keep) req_valid[g] = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || rsp_valid !== 1'b0 || req_ready !== '0) begin
      errors++;
      $display("FAIL calc_phase: busy=%b rsp_valid=%b req_ready=%b required 1 0 0000", busy, rsp_valid, req_ready);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== IDW'(g) || rsp_result !== exp_p || req_ready !== '0) begin
      errors++;
      $display("FAIL response: valid=%b id=%0d result=%h ready=%b required 1 %0d %h 0000",
               rsp_valid, rsp_id, rsp_result, req_ready, g, exp_p);
    end
    res = rsp_result;
    if (hold > 0) begin
      for (int i = 1; i < hold; i++) begin
        cyc();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== IDW'(g) || rsp_result !== exp_p || req_ready !== '0) begin
          errors++;
          $display("FAIL backpressure_hold: cycle=%0d valid=%b id=%0d result=%h ready=%b required 1 %0d %h 0000",
                   i, rsp_valid, rsp_id, rsp_result, req_ready, g, exp_p);
        end
      end
      cyc();
      rsp_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== exp_p) begin
        errors++;
        $display("FAIL hold_last: valid=%b result=%h required 1 %h", rsp_valid, rsp_result, exp_p);
      end
    end
    cyc();
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== '0 || rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_result !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b valid=%b id=%0d result=%h busy=%b required all 0",
               req_ready, rsp_valid, rsp_id, rsp_result, busy);
    end
    cyc();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_reset: busy=%b valid=%b required 0 0", busy, rsp_valid);
    end
    cyc();
  endtask

  task automatic test_single();
    int gid, gc;
    logic [63:0] res;
    set_ops(2, 32'd7, 32'hFFFF_FFFD);
    transact(4'b0100, 0, 1'b0, gid, res, gc);
    checks++;
    if (gid !== 2 || res !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      errors++;
      $display("FAIL single_req2: id=%0d result=%h required 2 ffffffffffffffeb", gid, res);
    end
  endtask

  task automatic test_corner();
    logic [31:0] ta [3] = '{32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF};
    logic [31:0] tb [3] = '{32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF};
    logic [63:0] tp [3] = '{64'h4000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000, 64'h3FFF_FFFF_0000_0001};
    int gid, gc;
    logic [63:0] res;
    for (int i = 0; i < 3; i++) begin
      set_ops(0, ta[i], tb[i]);
      transact(4'b0001, 0, 1'b0, gid, res, gc);
      checks++;
      if (res !== tp[i]) begin
        errors++;
        $display("FAIL corner_%0d: a=%h b=%h result=%h required %h", i, ta[i], tb[i], res, tp[i]);
      end
    end
  endtask

  task automatic test_round_robin();
    int gid, gc, prev_gc;
    logic [63:0] res;
`ifdef MULT_ARB_RR_EN
    int exp_order [5] = '{0, 1, 2, 3, 0};
`else
    int exp_order [5] = '{0, 0, 0, 0, 0};
`endif
    do_reset();
    for (int i = 0; i < NREQ; i++) set_ops(i, $urandom, $urandom);
    prev_gc = 0;
    for (int n = 0; n < 5; n++) begin
      transact(4'b1111, 0, 1'b1, gid, res, gc);
      checks++;
      if (gid !== exp_order[n]) begin
        errors++;
        $display("FAIL arb_order_%0d: granted=%0d required %0d", n, gid, exp_order[n]);
      end
      if (n > 0) begin
        checks++;
        if (gc - prev_gc !== 3) begin
          errors++;
          $display("FAIL issue_interval_%0d: cycles=%0d required 3", n, gc - prev_gc);
        end
      end
      prev_gc = gc;
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    int gid, gc;
    logic [63:0] res;
    set_ops(0, $urandom, $urandom);
    set_ops(1, $urandom, $urandom);
    transact(4'b0011, 5, 1'b0, gid, res, gc);
    req_valid = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== '0) begin
      errors++;
      $display("FAIL bp_complete: busy=%b valid=%b ready=%b required 0 0 0000", busy, rsp_valid, req_ready);
    end
    cyc();
  endtask

  task automatic test_reset_in_calc();
    int gid, gc;
    logic [63:0] res;
    set_ops(2, $urandom, $urandom);
    req_valid = 4'b0100;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL rc_grant: req_ready=%b required 0100", req_ready);
    end
    cyc();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rc_in_calc: busy=%b required 1", busy);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    m_ptr = 0;
    @(negedge clk);
    checks++;
    if (req_ready !== '0 || rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_result !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rc_outputs: ready=%b valid=%b id=%0d result=%h busy=%b required all 0",
               req_ready, rsp_valid, rsp_id, rsp_result, busy);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rc_no_response_%0d: valid=%b busy=%b required 0 0", i, rsp_valid, busy);
      end
    end
    cyc();
    set_ops(1, $urandom, $urandom);
    set_ops(3, $urandom, $urandom);
    transact(4'b1010, 0, 1'b0, gid, res, gc);
    req_valid = '0;
    checks++;
    if (gid !== 1) begin
      errors++;
      $display("FAIL rc_first_after_reset: granted=%0d required 1", gid);
    end
  endtask

  task automatic test_withdraw();
    seen3 = 0;
    watch3 = 1'b1;
    set_ops(0, $urandom, $urandom);
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL wd_grant0: req_ready=%b required 0001", req_ready);
    end
    cyc();
    m_ptr = 1;
    req_valid = 4'b1000;
    @(negedge clk);
    checks++;
    if (req_ready !== '0) begin
      errors++;
      $display("FAIL wd_busy_ready: req_ready=%b required 0000", req_ready);
    end
    cyc();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin
      errors++;
      $display("FAIL wd_response: valid=%b id=%0d required 1 0", rsp_valid, rsp_id);
    end
    cyc();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== '0) begin
        errors++;
        $display("FAIL wd_idle_%0d: busy=%b valid=%b ready=%b required 0 0 0000", i, busy, rsp_valid, req_ready);
      end
      cyc();
    end
    watch3 = 1'b0;
    checks++;
    if (seen3 !== 0) begin
      errors++;
      $display("FAIL wd_never_granted: grants_to_3=%0d required 0", seen3);
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_random();
    int gid, gc, hold;
    logic [63:0] res;
    logic [NREQ-1:0] v;
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < NREQ; i++) set_ops(i, $urandom, $urandom);
      v = NREQ'($urandom_range(1, 15));
      hold = $urandom_range(0, 2);
      transact(v, hold, 1'b0, gid, res, gc);
      $display("txn %0d: valid=%b granted=%0d result=%h", n, v, gid, res);
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_corner();
    test_round_robin();
    test_backpressure();
    test_reset_in_calc();
    test_withdraw();
    test_random();
    repeat (2) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
